// File: rtl/qmax_update_unit.sv
// qmax_update_unit
//   Read-modify-write front end for the qmax table. Each accepted (state, q)
//   sample reads the stored qmax. The new q is written back only if it is
//   strictly greater (signed). Same-state hazards are resolved by forwarding
//   from the write on the outputs this cycle and the write of the previous
//   cycle. A clear request drains the pipeline, then sweeps INIT_VAL over
//   every entry, one entry per cycle.
//
//   Optional feature macro: QMAX_UPD_STATS_EN enables the saturating
//   statistics counters. When it is undefined, both counters read as 0.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready       sample handshake; i_state, i_q carry the sample
//   i_clear               one-cycle pulse requesting a full table clear
//   o_qmax_read_en/addr_r table read port (data returns next cycle)
//   i_qmax_data           table read data
//   o_qmax_write_en/addr_w/wdata  table write port (registered)
//   o_busy                pipeline non-empty or clear in progress
//   o_upd_cnt, o_wr_cnt   accepted samples / improving writes (stats)
module qmax_update_unit #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter logic signed [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_clear,
  output logic                  o_qmax_read_en,
  output logic [ADDR_WIDTH-1:0] o_qmax_addr_r,
  input  logic [DATA_WIDTH-1:0] i_qmax_data,
  output logic                  o_qmax_write_en,
  output logic [ADDR_WIDTH-1:0] o_qmax_addr_w,
  output logic [DATA_WIDTH-1:0] o_qmax_wdata,
  output logic                  o_busy,
  output logic [15:0]           o_upd_cnt,
  output logic [15:0]           o_wr_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} fsm_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  fsm_t                  fsm;
  logic                  accept;
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_state;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  c_valid;
  logic                  lw_valid;
  logic [ADDR_WIDTH-1:0] lw_addr;
  logic [DATA_WIDTH-1:0] lw_data;
  logic [ADDR_WIDTH-1:0] sweep;
  logic [DATA_WIDTH-1:0] old_val;
  logic                  improve;

  assign o_ready        = (fsm == RUN) && !i_clear;
  assign accept         = i_valid && o_ready;
  assign o_qmax_read_en = accept;
  assign o_qmax_addr_r  = accept ? i_state : '0;
  assign o_busy         = b_valid || c_valid || (fsm != RUN);

  // The table read returns contents from before the edge. The write now on
  // the outputs and the write from the previous cycle are not yet visible in
  // i_qmax_data, so forward them. The newer write has priority.
  always_comb begin
    old_val = i_qmax_data;
    if (o_qmax_write_en && (o_qmax_addr_w == b_state))
      old_val = o_qmax_wdata;
    else if (lw_valid && (lw_addr == b_state))
      old_val = lw_data;
    improve = b_valid && ($signed(b_q) > $signed(old_val));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm             <= RUN;
      b_valid         <= 1'b0;
      b_state         <= '0;
      b_q             <= '0;
      c_valid         <= 1'b0;
      lw_valid        <= 1'b0;
      lw_addr         <= '0;
      lw_data         <= '0;
      sweep           <= '0;
      o_qmax_write_en <= 1'b0;
      o_qmax_addr_w   <= '0;
      o_qmax_wdata    <= '0;
    end else begin
      b_valid  <= accept;
      if (accept) begin
        b_state <= i_state;
        b_q     <= i_q;
      end
      c_valid  <= b_valid;
      lw_valid <= o_qmax_write_en;
      lw_addr  <= o_qmax_addr_w;
      lw_data  <= o_qmax_wdata;

      o_qmax_write_en <= 1'b0;
      if (improve) begin
        o_qmax_write_en <= 1'b1;
        o_qmax_addr_w   <= b_state;
        o_qmax_wdata    <= b_q;
      end

      case (fsm)
        RUN: begin
          if (i_clear) fsm <= DRAIN;
        end
        DRAIN: begin
          if (!b_valid && !c_valid) begin
            fsm      <= CLEAR;
            sweep    <= '0;
            lw_valid <= 1'b0;
          end
        end
        CLEAR: begin
          o_qmax_write_en <= 1'b1;
          o_qmax_addr_w   <= sweep;
          o_qmax_wdata    <= INIT_VAL;
          if (sweep == LAST_ADDR) fsm <= RUN;
          else sweep <= sweep + ADDR_WIDTH'(1);
        end
        default: fsm <= RUN;
      endcase
    end
  end

`ifdef QMAX_UPD_STATS_EN
  logic [15:0] upd_cnt;
  logic [15:0] wr_cnt;

  // c_valid separates sample writes from clear-sweep writes, which are not counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      upd_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (accept && (upd_cnt != '1)) upd_cnt <= upd_cnt + 16'd1;
      if (o_qmax_write_en && c_valid && (wr_cnt != '1)) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign o_upd_cnt = upd_cnt;
  assign o_wr_cnt  = wr_cnt;
`else
  assign o_upd_cnt = '0;
  assign o_wr_cnt  = '0;
`endif

endmodule

// File: tb/tb_qmax_update_unit.sv
module tb_qmax_update_unit;

  localparam int DEPTH = 64;
  localparam logic signed [31:0] TB_INIT = -32'sd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_clear;
  logic [5:0]  i_state;
  logic [31:0] i_q;
  logic        o_ready, o_qmax_read_en, o_qmax_write_en, o_busy;
  logic [5:0]  o_qmax_addr_r, o_qmax_addr_w;
  logic [31:0] i_qmax_data, o_qmax_wdata;
  logic [15:0] o_upd_cnt, o_wr_cnt;

  always #5 clk = ~clk;

  qmax_update_unit #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(DEPTH), .INIT_VAL(TB_INIT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_state(i_state), .i_q(i_q), .i_clear(i_clear),
    .o_qmax_read_en(o_qmax_read_en), .o_qmax_addr_r(o_qmax_addr_r),
    .i_qmax_data(i_qmax_data), .o_qmax_write_en(o_qmax_write_en),
    .o_qmax_addr_w(o_qmax_addr_w), .o_qmax_wdata(o_qmax_wdata),
    .o_busy(o_busy), .o_upd_cnt(o_upd_cnt), .o_wr_cnt(o_wr_cnt)
  );

  // Table memory: synchronous read, read-before-write on the same address.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (o_qmax_read_en) i_qmax_data <= mem[o_qmax_addr_r];
    if (o_qmax_write_en) mem[o_qmax_addr_w] <= o_qmax_wdata;
  end

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          stamp;  // required cycle, 0 = any (clear sweep)
    bit          clr;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [31:0] ref_tbl [DEPTH];
  logic signed [31:0] ref_snap [DEPTH];
  int  cycle = 0;
  int  errors = 0;
  int  checks = 0;
  int  exp_upd = 0;
  int  exp_wr = 0;
  bit  in_sweep = 1'b0;

  function automatic int stat_exp(input int v);
`ifdef QMAX_UPD_STATS_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor / scoreboard: samples mid-cycle, models accepts and clears.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (!rst_n) begin
      exp_q.delete();
      in_sweep = 1'b0;
      exp_upd  = 0;
      exp_wr   = 0;
    end else begin
      if (o_qmax_write_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%0d cycle=%0d", o_qmax_addr_w, $signed(o_qmax_wdata), cycle);
        end else begin
          e = exp_q.pop_front();
          if (o_qmax_addr_w != e.addr[5:0] || o_qmax_wdata !== e.data || (e.stamp != 0 && cycle != e.stamp)) begin
            errors++;
            $display("FAIL write got addr=%0d data=%0d cycle=%0d want addr=%0d data=%0d cycle=%0d",
                     o_qmax_addr_w, $signed(o_qmax_wdata), cycle, e.addr, $signed(e.data), e.stamp);
          end
          if (e.clr && e.addr == DEPTH - 1) in_sweep = 1'b0;
        end
      end else if (exp_q.size() != 0 && exp_q[0].stamp != 0 && exp_q[0].stamp <= cycle) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_write got none want addr=%0d data=%0d cycle=%0d", e.addr, $signed(e.data), e.stamp);
      end

      check("ready", {31'b0, o_ready}, {31'b0, !in_sweep && !i_clear});

      if (i_valid && o_ready) begin
        check("read_en", {31'b0, o_qmax_read_en}, 32'd1);
        check("read_addr", {26'b0, o_qmax_addr_r}, {26'b0, i_state});
        exp_upd++;
        if ($signed(i_q) > ref_tbl[i_state]) begin
          ref_tbl[i_state] = $signed(i_q);
          exp_q.push_back('{addr: int'(i_state), data: i_q, stamp: cycle + 2, clr: 1'b0});
          exp_wr++;
        end
      end

      if (i_clear && !in_sweep) begin
        in_sweep = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
          exp_q.push_back('{addr: a, data: TB_INIT, stamp: 0, clr: 1'b1});
          ref_tbl[a] = TB_INIT;
        end
      end
    end
  end

  task automatic drive(input bit v, input int s, input int q, input bit c);
    @(posedge clk); #1;
    i_valid = v; i_state = s[5:0]; i_q = q; i_clear = c;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic wait_done;
    int budget;
    budget = 0;
    while ((in_sweep || o_busy || exp_q.size() != 0) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 400) begin
      errors++;
      $display("FAIL wait_done timeout pending=%0d busy=%0d", exp_q.size(), o_busy);
    end
  endtask

  task automatic do_clear;
    drive(1'b0, 0, 0, 1'b1);
    idle(1);
    wait_done();
  endtask

  task automatic check_reset_outputs;
    check("rst_write_en", {31'b0, o_qmax_write_en}, 32'd0);
    check("rst_addr_w", {26'b0, o_qmax_addr_w}, 32'd0);
    check("rst_wdata", o_qmax_wdata, 32'd0);
    check("rst_read_en", {31'b0, o_qmax_read_en}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_upd_cnt", {16'b0, o_upd_cnt}, 32'd0);
    check("rst_wr_cnt", {16'b0, o_wr_cnt}, 32'd0);
  endtask

  task automatic check_stats;
    @(negedge clk);
    check("upd_cnt", {16'b0, o_upd_cnt}, stat_exp(exp_upd));
    check("wr_cnt", {16'b0, o_wr_cnt}, stat_exp(exp_wr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_state = '0; i_q = '0;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = $urandom;
      ref_tbl[a] = TB_INIT;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full sweep from an unknown table.
    do_clear();

    // Repeated state: improve, lower, equal.
    drive(1'b1, 5, 10, 1'b0);
    drive(1'b1, 5, 7, 1'b0);
    drive(1'b1, 5, 10, 1'b0);
    idle(4);

    // Back-to-back same state: forwarding from both write registers.
    drive(1'b1, 9, 3, 1'b0);
    drive(1'b1, 9, 8, 1'b0);
    drive(1'b1, 9, 4, 1'b0);
    drive(1'b1, 9, 12, 1'b0);
    idle(4);

    // Signed compare against a stored 0, then against INIT_VAL.
    drive(1'b1, 2, 0, 1'b0);
    idle(3);
    drive(1'b1, 2, -5, 1'b0);
    idle(3);
    do_clear();
    drive(1'b1, 2, -5, 1'b0);
    idle(4);
    check_stats();

    // Clear with two samples in flight and i_valid held high throughout.
    drive(1'b1, 1, 40, 1'b0);
    drive(1'b1, 3, 40, 1'b0);
    drive(1'b1, 4, 99, 1'b1);
    for (int k = 0; k < 90; k++) drive(1'b1, $urandom_range(0, 7), int'($urandom_range(0, 200)) - 100, 1'b0);
    idle(2);
    wait_done();

    // Random mix, including clear pulses issued during a sweep.
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 99);
      drive(r < 75, (r < 60) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1),
            int'($urandom_range(0, 200)) - 100, $urandom_range(0, 69) == 0);
    end
    idle(2);
    wait_done();
    idle(3);
    check_stats();
    check("queue_empty", exp_q.size(), 32'd0);
    for (int a = 0; a < DEPTH; a++) check($sformatf("table_%0d", a), mem[a], ref_tbl[a]);

    // Reset one cycle after an accept: the write must be dropped.
    do_clear();
    ref_snap = ref_tbl;
    drive(1'b1, 7, 50, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_tbl = ref_snap;
    idle(6);
    @(negedge clk);
    check_reset_outputs();
    check("table_7_after_reset", mem[7], TB_INIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
